// File: rtl/parity_stream_unit.sv
// Single registered stage that generates and checks per-word parity on a valid/ready stream,
// keeping a running frame parity and a saturating mismatch count across in_last-delimited frames.
module parity_stream_unit #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_par,
  input  logic             in_last,
  input  logic             mode_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_par,
  output logic             out_err,
  output logic             out_last,
  output logic             frame_par,
  output logic [CNT_W-1:0] frame_errs
);

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q;
  logic             mode_q;
  logic             acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             mode_w;
  logic             word_x;
  logic             word_p;
  logic             word_err;
  logic             acc_d;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    word_x   = ^in_data;
    // The first word of a frame uses the live mode; later words use the latched one.
    mode_w   = (state_q == StIdle) ? mode_odd : mode_q;
    word_p   = word_x ^ mode_w;
    word_err = word_p ^ in_par;
    acc_d    = (state_q == StIdle) ? word_x : (acc_q ^ word_x);
    cnt_base = (state_q == StIdle) ? '0 : cnt_q;
    if (cnt_base == CntMax) begin
      cnt_d = cnt_base;
    end else begin
      cnt_d = cnt_base + CNT_W'(word_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_par    <= 1'b0;
      out_err    <= 1'b0;
      out_last   <= 1'b0;
      frame_par  <= 1'b0;
      frame_errs <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= in_data;
      out_par    <= word_p;
      out_err    <= word_err;
      out_last   <= in_last;
      frame_par  <= acc_d ^ mode_w;
      frame_errs <= cnt_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_w;
      unique case (state_q)
        StIdle:    state_q <= in_last ? StIdle : StInFrame;
        StInFrame: state_q <= in_last ? StIdle : StInFrame;
        default:   state_q <= StIdle;
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic against a
// frame-level reference model. A second instance with CNT_W=2 exercises counter saturation.
module tb_parity_stream_unit;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready, in_ready_s;
  logic [W-1:0]  in_data;
  logic          in_par;
  logic          in_last;
  logic          mode_odd;
  logic          out_ready;
  logic          out_valid, out_valid_s;
  logic [W-1:0]  out_data, out_data_s;
  logic          out_par, out_par_s;
  logic          out_err, out_err_s;
  logic          out_last, out_last_s;
  logic          frame_par, frame_par_s;
  logic [7:0]    frame_errs;
  logic [1:0]    frame_errs_s;

  parity_stream_unit #(.W(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_par(in_par), .in_last(in_last), .mode_odd(mode_odd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_par(out_par), .out_err(out_err),
    .out_last(out_last), .frame_par(frame_par), .frame_errs(frame_errs)
  );

  parity_stream_unit #(.W(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_par(in_par), .in_last(in_last), .mode_odd(mode_odd), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_par(out_par_s), .out_err(out_err_s),
    .out_last(out_last_s), .frame_par(frame_par_s), .frame_errs(frame_errs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: frame contents kept as a list of words, parity from bit counts.
  logic          m_in_frame;
  logic          m_mode;
  logic [W-1:0]  m_words[$];
  int            m_errs;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_par, m_err, m_last, m_fpar;
  int            m_ferrs;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_in_frame = 1'b0; m_mode = 1'b0; m_words.delete(); m_errs = 0;
    m_valid = 1'b0; m_data = '0; m_par = 1'b0; m_err = 1'b0; m_last = 1'b0;
    m_fpar = 1'b0; m_ferrs = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_valid_sat"}, 32'(out_valid_s), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
      chk({tag, ".out_par"}, 32'(out_par), 32'(m_par));
      chk({tag, ".out_err"}, 32'(out_err), 32'(m_err));
      chk({tag, ".out_last"}, 32'(out_last), 32'(m_last));
      chk({tag, ".frame_par"}, 32'(frame_par), 32'(m_fpar));
      chk({tag, ".frame_errs"}, 32'(frame_errs), 32'(sat(m_ferrs, 255)));
      chk({tag, ".frame_errs_sat"}, 32'(frame_errs_s), 32'(sat(m_ferrs, 3)));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.frame_errs", 32'(frame_errs), 32'd0);
    chk("rst.frame_par", 32'(frame_par), 32'd0);
  endtask

  // One clock: apply inputs, check in_ready, advance model, check registered outputs.
  task automatic tick(input string tag, input logic v, input logic [W-1:0] d, input logic p,
                      input logic l, input logic m, input logic r);
    logic exp_ready;
    int   ones;
    in_valid = v; in_data = d; in_par = p; in_last = l; mode_odd = m; out_ready = r;
    #1;
    exp_ready = !m_valid || r;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    if (v && exp_ready) begin
      if (!m_in_frame) begin
        m_mode = m; m_words.delete(); m_errs = 0;
      end
      m_words.push_back(d);
      m_par = 1'($countones(d) % 2) ^ m_mode;
      m_err = m_par ^ p;
      m_errs += int'(m_err);
      ones = 0;
      foreach (m_words[i]) ones += $countones(m_words[i]);
      m_fpar = 1'(ones % 2) ^ m_mode;
      m_ferrs = m_errs; m_data = d; m_last = l; m_valid = 1'b1;
      m_in_frame = !l;
    end else if (r) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic         p;
    logic         l;
    logic         m;
    logic         ov;
    logic         opar;
    logic         oerr;
    logic         fpar;
    logic [7:0]   ferr;
    logic [1:0]   ferr_s;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0; in_last = 1'b0;
    mode_odd = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    //           v  data      p  l  m  ov par err fpar ferr ferr_s
    vecs[0]  = '{1, 16'h0001, 1, 1, 0, 1, 1,  0,  1,   0,   0};
    vecs[1]  = '{1, 16'h0000, 0, 1, 1, 1, 1,  1,  1,   1,   1};
    vecs[2]  = '{1, 16'h0003, 0, 0, 0, 1, 0,  0,  0,   0,   0};
    vecs[3]  = '{1, 16'h0001, 0, 0, 1, 1, 1,  1,  1,   1,   1};
    vecs[4]  = '{1, 16'h8000, 0, 1, 1, 1, 1,  1,  0,   2,   2};
    vecs[5]  = '{1, 16'h0000, 1, 0, 0, 1, 0,  1,  0,   1,   1};
    vecs[6]  = '{1, 16'h0000, 1, 0, 0, 1, 0,  1,  0,   2,   2};
    vecs[7]  = '{1, 16'h0000, 1, 0, 0, 1, 0,  1,  0,   3,   3};
    vecs[8]  = '{1, 16'h0000, 1, 0, 0, 1, 0,  1,  0,   4,   3};
    vecs[9]  = '{1, 16'h0000, 1, 1, 0, 1, 0,  1,  0,   5,   3};
    vecs[10] = '{0, 16'h0000, 0, 0, 0, 0, 0,  0,  0,   0,   0};

    for (int i = 0; i < 11; i++) begin
      tick($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].p, vecs[i].l, vecs[i].m, 1'b1);
      chk($sformatf("vec%0d.tbl_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d.tbl_data", i), 32'(out_data), 32'(vecs[i].d));
        chk($sformatf("vec%0d.tbl_par", i), 32'(out_par), 32'(vecs[i].opar));
        chk($sformatf("vec%0d.tbl_err", i), 32'(out_err), 32'(vecs[i].oerr));
        chk($sformatf("vec%0d.tbl_last", i), 32'(out_last), 32'(vecs[i].l));
        chk($sformatf("vec%0d.tbl_fpar", i), 32'(frame_par), 32'(vecs[i].fpar));
        chk($sformatf("vec%0d.tbl_ferr", i), 32'(frame_errs), 32'(vecs[i].ferr));
        chk($sformatf("vec%0d.tbl_ferr_sat", i), 32'(frame_errs_s), 32'(vecs[i].ferr_s));
      end
    end

    // Backpressure: a word held while the consumer stalls, then a back-to-back drain.
    tick("bp_load", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("bp_stall%0d", i), 1'b1, 16'hBEEF + 16'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("bp_stall%0d.in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_stall%0d.hold", i), 32'(out_data), 32'h1234);
    end
    for (int i = 0; i < 4; i++) begin
      tick($sformatf("bp_drain%0d", i), 1'b1, 16'h0100 + 16'(i), 1'b0, 1'(i == 3), 1'b0, 1'b1);
      chk($sformatf("bp_drain%0d.order", i), 32'(out_data), 32'h0100 + 32'(i));
    end
    tick("bp_idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame discards it.
    tick("mid0", 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("mid1", 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1);
    do_reset();
    tick("post_rst", 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("post_rst.frame_par", 32'(frame_par), 32'd1);
    chk("post_rst.frame_errs", 32'(frame_errs), 32'd0);

    // Randomized traffic, including stalls, gaps and the odd reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        tick("rnd", 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
